// File: rtl/cpu_core_mc_pkg.sv
// Shared definitions for the multi-cycle 18-bit core.
// Opcodes, FSM states, ALU operations and decoded-instruction bundle.
package cpu_core_mc_pkg;

    localparam int INSN_W = 18;

    localparam int OP_HI  = 17;
    localparam int OP_LO  = 14;
    localparam int RX_HI  = 13;
    localparam int RX_LO  = 11;
    localparam int RY_HI  = 10;
    localparam int RY_LO  = 8;
    localparam int RZ_HI  = 7;
    localparam int RZ_LO  = 5;
    localparam int AOP_HI = 3;
    localparam int AOP_LO = 0;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LDI   = 4'd1;
    localparam logic [3:0] OP_ALU   = 4'd2;
    localparam logic [3:0] OP_LOAD  = 4'd3;
    localparam logic [3:0] OP_ADDI  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_BNZ   = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;

    localparam logic [3:0] ALU_REG0 = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_NOT  = 4'd6;
    localparam logic [3:0] ALU_SHL  = 4'd7;
    localparam logic [3:0] ALU_SHR  = 4'd8;

    typedef enum logic [1:0] {RUN, MEM, HALT} state_t;

    typedef enum logic [1:0] {WB_IMM, WB_ALU, WB_ADDI} wsel_t;

    typedef struct packed {
        logic       rf_we;
        wsel_t      wsel;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [2:0] rz;
        logic [3:0] aluop;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_halt;
        logic       is_illegal;
    } dec_t;

endpackage

// File: rtl/cpu_core_mc_if.sv
// Handshaked data-memory port: request held until acknowledged.
// master = core, slave = data RAM / bus arbiter.
interface cpu_core_mc_if #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18
);
    logic                 data_req;
    logic                 data_we;
    logic [ADDR_SIZE-1:0] data_addr;
    logic [WORD_SIZE-1:0] data_wdata;
    logic [WORD_SIZE-1:0] data_rdata;
    logic                 data_ack;

    modport master (
        output data_req, data_we, data_addr, data_wdata,
        input  data_rdata, data_ack
    );

    modport slave (
        input  data_req, data_we, data_addr, data_wdata,
        output data_rdata, data_ack
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU; unknown operations pass operand a through.
// Results are truncated to WORD_SIZE.
module alu
    import cpu_core_mc_pkg::*;
#(
    parameter int WORD_SIZE = 18
) (
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    input  logic [3:0]           op_i,
    output logic [WORD_SIZE-1:0] y_o
);
    always_comb begin
        y_o = a_i;
        unique case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_NOT: y_o = ~a_i;
            ALU_SHL: y_o = a_i << 1;
            ALU_SHR: y_o = a_i >> 1;
            default: y_o = a_i;
        endcase
    end
endmodule

// File: rtl/cpu_decode.sv
// Instruction decoder: 18-bit code word to control bundle and immediate.
// Reserved opcodes decode as a NOP with the illegal flag set.
module cpu_decode
    import cpu_core_mc_pkg::*;
#(
    parameter int WORD_SIZE = 18
) (
    input  logic [INSN_W-1:0]    code_word_i,
    output dec_t                 dec_o,
    output logic [WORD_SIZE-1:0] imm_o
);
    logic [3:0]           op;
    logic [WORD_SIZE-1:0] imm11;
    logic [WORD_SIZE-1:0] imm8;
    logic                 unused_bit;

    assign op    = code_word_i[OP_HI:OP_LO];
    assign imm11 = {{(WORD_SIZE-11){code_word_i[10]}}, code_word_i[10:0]};
    assign imm8  = {{(WORD_SIZE-8){code_word_i[7]}}, code_word_i[7:0]};
    assign unused_bit = code_word_i[4];

    always_comb begin
        dec_o       = '0;
        dec_o.rx    = code_word_i[RX_HI:RX_LO];
        dec_o.ry    = code_word_i[RY_HI:RY_LO];
        dec_o.rz    = code_word_i[RZ_HI:RZ_LO];
        dec_o.aluop = code_word_i[AOP_HI:AOP_LO];
        imm_o       = imm8;
        unique case (op)
            OP_NOP: ;
            OP_LDI: begin
                dec_o.rf_we = 1'b1;
                dec_o.wsel  = WB_IMM;
                imm_o       = imm11;
            end
            OP_ALU: begin
                dec_o.rf_we = 1'b1;
                dec_o.wsel  = WB_ALU;
            end
            OP_LOAD:  dec_o.is_load = 1'b1;
            OP_ADDI: begin
                dec_o.rf_we = 1'b1;
                dec_o.wsel  = WB_ADDI;
            end
            OP_STORE: dec_o.is_store = 1'b1;
            OP_BNZ: begin
                dec_o.is_branch = 1'b1;
                imm_o           = imm11;
            end
            OP_HALT:  dec_o.is_halt = 1'b1;
            default:  dec_o.is_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/regfile.sv
// Eight-entry register file, three combinational reads, one write.
// Contents are deliberately not reset.
module regfile #(
    parameter int WORD_SIZE = 18
) (
    input  logic                 clock,
    input  logic                 we_i,
    input  logic [2:0]           waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [2:0]           raddr_x_i,
    input  logic [2:0]           raddr_y_i,
    input  logic [2:0]           raddr_z_i,
    output logic [WORD_SIZE-1:0] rdata_x_o,
    output logic [WORD_SIZE-1:0] rdata_y_o,
    output logic [WORD_SIZE-1:0] rdata_z_o
);
    logic [WORD_SIZE-1:0] regs_q [8];

    always_ff @(posedge clock) begin
        if (we_i) regs_q[waddr_i] <= wdata_i;
    end

    assign rdata_x_o = regs_q[raddr_x_i];
    assign rdata_y_o = regs_q[raddr_y_i];
    assign rdata_z_o = regs_q[raddr_z_i];
endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle 18-bit core: RUN executes, MEM waits for the data
// port acknowledge, HALT is absorbing until reset.
module cpu_core_mc
    import cpu_core_mc_pkg::*;
#(
    parameter int                   ADDR_SIZE = 18,
    parameter int                   WORD_SIZE = 18,
    parameter logic [ADDR_SIZE-1:0] RESET_IP  = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [ADDR_SIZE-1:0] code_addr_o,
    input  logic [INSN_W-1:0]    code_word_i,
    cpu_core_mc_if.master        mem,
    output logic                 halted_o,
    output logic                 illegal_o
);
    state_t               state_q;
    logic [ADDR_SIZE-1:0] ip_q;
    logic                 req_q;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [2:0]           dest_q;
    logic                 halted_q;
    logic                 illegal_q;

    dec_t                 dec;
    logic [WORD_SIZE-1:0] imm;
    logic [WORD_SIZE-1:0] rx_v;
    logic [WORD_SIZE-1:0] ry_v;
    logic [WORD_SIZE-1:0] rz_v;
    logic [WORD_SIZE-1:0] alu_y;
    logic [WORD_SIZE-1:0] ea;
    logic                 rf_we;
    logic [2:0]           rf_waddr;
    logic [WORD_SIZE-1:0] rf_wdata;

    cpu_decode #(.WORD_SIZE(WORD_SIZE)) u_dec (
        .code_word_i (code_word_i),
        .dec_o       (dec),
        .imm_o       (imm)
    );

    regfile #(.WORD_SIZE(WORD_SIZE)) u_rf (
        .clock     (clock),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_x_i (dec.rx),
        .raddr_y_i (dec.ry),
        .raddr_z_i (dec.rz),
        .rdata_x_o (rx_v),
        .rdata_y_o (ry_v),
        .rdata_z_o (rz_v)
    );

    alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .a_i  (ry_v),
        .b_i  (rz_v),
        .op_i (dec.aluop),
        .y_o  (alu_y)
    );

    assign ea = ry_v + imm;

    // Reset suppresses every register write, including a pending load.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = dec.rx;
        rf_wdata = imm;
        if (!reset && state_q == RUN && dec.rf_we) begin
            rf_we = 1'b1;
            unique case (dec.wsel)
                WB_ALU:  rf_wdata = alu_y;
                WB_ADDI: rf_wdata = ea;
                default: rf_wdata = imm;
            endcase
        end else if (!reset && state_q == MEM && mem.data_ack && !we_q) begin
            rf_we    = 1'b1;
            rf_waddr = dest_q;
            rf_wdata = mem.data_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            ip_q      <= RESET_IP;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dest_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    ip_q      <= ip_q + ADDR_SIZE'(1);
                    illegal_q <= dec.is_illegal;
                    if (dec.is_load || dec.is_store) begin
                        state_q <= MEM;
                        ip_q    <= ip_q;
                        req_q   <= 1'b1;
                        we_q    <= dec.is_store;
                        addr_q  <= ea[ADDR_SIZE-1:0];
                        wdata_q <= rx_v;
                        dest_q  <= dec.rx;
                    end else if (dec.is_halt) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                        ip_q     <= ip_q;
                    end else if (dec.is_branch && rx_v != '0) begin
                        ip_q <= ip_q + imm[ADDR_SIZE-1:0];
                    end
                end
                MEM: begin
                    if (mem.data_ack) begin
                        state_q <= RUN;
                        req_q   <= 1'b0;
                        ip_q    <= ip_q + ADDR_SIZE'(1);
                    end
                end
                HALT: ;
                default: state_q <= HALT;
            endcase
        end
    end

    assign code_addr_o    = ip_q;
    assign mem.data_req   = req_q;
    assign mem.data_we    = we_q;
    assign mem.data_addr  = addr_q;
    assign mem.data_wdata = wdata_q;
    assign halted_o       = halted_q;
    assign illegal_o      = illegal_q;
endmodule
